control_multiciclo: RTL and testbench
=====================================

# control_multiciclo

Multicycle sequencer that replaces the single-cycle opcode decoder when the processor datapath is time-shared: one ALU, one unified memory port and the register bank are reused across FETCH/DECODE/EXEC/MEM/WB steps. It takes the 6-bit opcode, the ALU zero flag and a memory-ready handshake. It drives every datapath strobe and mux select, one state per clock.

## Interface
Parameters:
- ANCHO_ESTADO, 4, width of the `estado` debug output.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- instru  in  6  opcode, IR[31:26]; valid from DECODE onward.
- oZero  in  1  ALU zero flag, sampled in BRANCH.
- mem_listo  in  1  memory-ready; completes a FETCH/MEM_RD/MEM_WR access.
- EscrPC  out  1  PC write, unconditional.
- EscrPCCond  out  1  PC write qualified internally by oZero; asserted as EscrPC in BRANCH.
- EscrIR  out  1  instruction register load.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- LeerMem  out  1  memory read.
- EscrMem  out  1  memory write.
- MemaReg  out  1  write-back select: 1 = MDR, 0 = ALUOut.
- RegDest  out  1  1 = rd, 0 = rt.
- EscrReg  out  1  register bank write.
- FuenteALUA  out  1  0 = PC, 1 = rs.
- FuenteALUB  out  2  00 = rt, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2.
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct-decoded.
- FuentePC  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- estado  out  ANCHO_ESTADO  current state code.
- ilegal  out  1  one-cycle pulse on unsupported opcode.

## Operation
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC_R=6, WB_R=7, BRANCH=8, EXEC_I=9, WB_I=10, JUMP=11.
- FETCH: IorD=0, LeerMem=1, FuenteALUA=0, FuenteALUB=01, ALUOp=00, FuentePC=00.
  - EscrIR and EscrPC are asserted only while mem_listo=1.
  - Holds FETCH until mem_listo=1, then goes to DECODE.
- DECODE: FuenteALUA=0, FuenteALUB=11, ALUOp=00 (branch target into ALUOut). Dispatch on instru:
  - 000000 → EXEC_R
  - 100011 or 101011 → MEMADR
  - 000100 → BRANCH
  - 001000 → EXEC_I
  - 000010 → JUMP (only when the macro is defined)
  - anything else → FETCH, with ilegal=1 for this cycle.
- MEMADR: FuenteALUA=1, FuenteALUB=10, ALUOp=00. Goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: IorD=1, LeerMem=1. Holds until mem_listo=1, then MEM_WB.
- MEM_WB: RegDest=0, MemaReg=1, EscrReg=1. Then FETCH.
- MEM_WR: IorD=1, EscrMem=1. Holds until mem_listo=1, then FETCH.
- EXEC_R: FuenteALUA=1, FuenteALUB=00, ALUOp=10. Then WB_R.
- WB_R: RegDest=1, MemaReg=0, EscrReg=1. Then FETCH.
- EXEC_I: FuenteALUA=1, FuenteALUB=10, ALUOp=00. Then WB_I.
- WB_I: RegDest=0, MemaReg=0, EscrReg=1. Then FETCH.
- BRANCH: FuenteALUA=1, FuenteALUB=00, ALUOp=01, FuentePC=01, EscrPCCond=1. EscrPC = oZero. Then FETCH.
- JUMP: FuentePC=10, EscrPC=1. Then FETCH.
- Every output not listed for a state is 0.
- Outputs are a Moore decode of the state register. The only exceptions are the mem_listo gating in FETCH and the oZero term in BRANCH.
- Unreachable codes 12–15 decode to all-zero outputs and return to FETCH next cycle.

## Timing
- While reset=0: state is FETCH and every output is forced to 0, including estado=0 and ilegal=0.
- Outputs follow state combinationally from the first edge after release.
- Reset asserted mid-instruction aborts immediately. No EscrReg/EscrMem/EscrPC is issued after assertion.
- Cycles per instruction with mem_listo always 1: R-type 4, addi 4, lw 5, sw 4, beq 3, j 3, illegal 2.
- Each cycle mem_listo=0 in FETCH/MEM_RD/MEM_WR adds one cycle. Strobes stay stable while waiting.
- EscrMem stays asserted through the wait and drops in the cycle after the mem_listo=1 edge.
- mem_listo is ignored in all other states.

## Configuration
- JUMP_EN defined: opcode 000010 → JUMP as described.
- JUMP_EN undefined: JUMP state absent, opcode 000010 is illegal (ilegal pulse, return to FETCH), FuentePC never equals 10.

## Structure
- Shared package proc_pkg holds:
  - state encoding
  - opcode constants (OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J)
  - ALUOp, FuenteALUB and FuentePC encodings
- One natural sub-module: control_salidas, a purely combinational state→strobe decoder.
- Next-state logic and the state register stay in the top.

## Test plan
- Reset low for 3 cycles, mid-lw (in MEM_RD) → all outputs 0, estado=0. After release, FETCH with LeerMem=1, IorD=0.
- instru=000000, mem_listo=1 → estado 0,1,6,7,0. EscrReg=1 with RegDest=1 in state 7 only.
- instru=100011, mem_listo low 2 cycles in MEM_RD → estado 0,1,2,3,3,3,4,0. LeerMem=1, IorD=1 through the waits.
- instru=000100 with oZero=1, then oZero=0 → EscrPC=1 with FuentePC=01 in BRANCH, then EscrPC=0. Both 3 cycles.
- instru=111111 → estado 0,1,0 with a single ilegal pulse in DECODE. No write strobe.
- instru=000010 → with JUMP_EN: estado 0,1,11,0, EscrPC=1, FuentePC=10. Without JUMP_EN: ilegal pulse.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared encodings for the multicycle control path: state codes, opcodes,
// mux-select encodings and the bundled strobe word.
package proc_pkg;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEM_RD = 4'd3,
    ST_MEM_WB = 4'd4,
    ST_MEM_WR = 4'd5,
    ST_EXEC_R = 4'd6,
    ST_WB_R   = 4'd7,
    ST_BRANCH = 4'd8,
    ST_EXEC_I = 4'd9,
    ST_WB_I   = 4'd10,
    ST_JUMP   = 4'd11
  } estado_t;

  typedef enum logic [5:0] {
    OP_R    = 6'b000000,
    OP_J    = 6'b000010,
    OP_BEQ  = 6'b000100,
    OP_ADDI = 6'b001000,
    OP_LW   = 6'b100011,
    OP_SW   = 6'b101011
  } opcode_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCB_RT      = 2'b00,
    SRCB_CUATRO  = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } fuente_b_t;

  typedef enum logic [1:0] {
    PC_ALU    = 2'b00,
    PC_ALUOUT = 2'b01,
    PC_SALTO  = 2'b10
  } fuente_pc_t;

  typedef struct packed {
    logic       escr_pc;
    logic       escr_pc_cond;
    logic       escr_ir;
    logic       iord;
    logic       leer_mem;
    logic       escr_mem;
    logic       mema_reg;
    logic       reg_dest;
    logic       escr_reg;
    logic       fuente_alu_a;
    fuente_b_t  fuente_alu_b;
    alu_op_t    alu_op;
    fuente_pc_t fuente_pc;
  } ctrl_t;

endpackage

// File: rtl/control_salidas.sv
// Combinational state -> strobe decoder for the multicycle sequencer.
// JUMP_EN enables decoding of the JUMP state; otherwise that code is all-zero.
module control_salidas
  import proc_pkg::*;
(
  input  estado_t estado,
  input  logic    mem_listo,
  input  logic    oZero,
  output ctrl_t   ctrl
);

  always_comb begin
    // NOTE: every field gets a default before the case so no latch is inferred.
    ctrl = '0;
    unique case (estado)
      ST_FETCH: begin
        ctrl.leer_mem     = 1'b1;
        ctrl.fuente_alu_b = SRCB_CUATRO;
        ctrl.alu_op       = ALU_ADD;
        ctrl.fuente_pc    = PC_ALU;
        // IR and PC only capture once memory has delivered the word.
        ctrl.escr_ir      = mem_listo;
        ctrl.escr_pc      = mem_listo;
      end
      ST_DECODE: begin
        ctrl.fuente_alu_b = SRCB_IMM_SH2;
        ctrl.alu_op       = ALU_ADD;
      end
      ST_MEMADR, ST_EXEC_I: begin
        ctrl.fuente_alu_a = 1'b1;
        ctrl.fuente_alu_b = SRCB_IMM;
        ctrl.alu_op       = ALU_ADD;
      end
      ST_MEM_RD: begin
        ctrl.iord     = 1'b1;
        ctrl.leer_mem = 1'b1;
      end
      ST_MEM_WB: begin
        ctrl.mema_reg = 1'b1;
        ctrl.escr_reg = 1'b1;
      end
      ST_MEM_WR: begin
        ctrl.iord     = 1'b1;
        ctrl.escr_mem = 1'b1;
      end
      ST_EXEC_R: begin
        ctrl.fuente_alu_a = 1'b1;
        ctrl.fuente_alu_b = SRCB_RT;
        ctrl.alu_op       = ALU_FUNCT;
      end
      ST_WB_R: begin
        ctrl.reg_dest = 1'b1;
        ctrl.escr_reg = 1'b1;
      end
      ST_WB_I: begin
        ctrl.escr_reg = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.fuente_alu_a = 1'b1;
        ctrl.fuente_alu_b = SRCB_RT;
        ctrl.alu_op       = ALU_SUB;
        ctrl.fuente_pc    = PC_ALUOUT;
        ctrl.escr_pc_cond = 1'b1;
        ctrl.escr_pc      = oZero;
      end
`ifdef JUMP_EN
      ST_JUMP: begin
        ctrl.fuente_pc = PC_SALTO;
        ctrl.escr_pc   = 1'b1;
      end
`endif
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/control_multiciclo.sv
// Multicycle control sequencer: state register, next-state dispatch and
// reset gating of all strobes. JUMP_EN adds the j opcode via a JUMP state.
module control_multiciclo
  import proc_pkg::*;
#(
  parameter int ANCHO_ESTADO = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [5:0]              instru,
  input  logic                    oZero,
  input  logic                    mem_listo,
  output logic                    EscrPC,
  output logic                    EscrPCCond,
  output logic                    EscrIR,
  output logic                    IorD,
  output logic                    LeerMem,
  output logic                    EscrMem,
  output logic                    MemaReg,
  output logic                    RegDest,
  output logic                    EscrReg,
  output logic                    FuenteALUA,
  output logic [1:0]              FuenteALUB,
  output logic [1:0]              ALUOp,
  output logic [1:0]              FuentePC,
  output logic [ANCHO_ESTADO-1:0] estado,
  output logic                    ilegal
);

  estado_t estado_q, estado_d;
  logic    ilegal_d;
  ctrl_t   ctrl_raw, ctrl;

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignment only.
    if (!reset) estado_q <= ST_FETCH;
    else        estado_q <= estado_d;
  end

  always_comb begin
    estado_d = estado_q;
    ilegal_d = 1'b0;
    unique case (estado_q)
      ST_FETCH:  if (mem_listo) estado_d = ST_DECODE;
      ST_DECODE: begin
        unique case (instru)
          OP_R:         estado_d = ST_EXEC_R;
          OP_LW, OP_SW: estado_d = ST_MEMADR;
          OP_BEQ:       estado_d = ST_BRANCH;
          OP_ADDI:      estado_d = ST_EXEC_I;
`ifdef JUMP_EN
          OP_J:         estado_d = ST_JUMP;
`endif
          default: begin
            estado_d = ST_FETCH;
            ilegal_d = 1'b1;
          end
        endcase
      end
      ST_MEMADR: estado_d = (instru == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD: if (mem_listo) estado_d = ST_MEM_WB;
      ST_MEM_WR: if (mem_listo) estado_d = ST_FETCH;
      ST_EXEC_R: estado_d = ST_WB_R;
      ST_EXEC_I: estado_d = ST_WB_I;
      default:   estado_d = ST_FETCH;
    endcase
  end

  control_salidas u_salidas (
    .estado    (estado_q),
    .mem_listo (mem_listo),
    .oZero     (oZero),
    .ctrl      (ctrl_raw)
  );

  // Reset level masks the decode so no strobe escapes while reset is held.
  assign ctrl   = reset ? ctrl_raw : '0;
  assign ilegal = reset & ilegal_d;
  assign estado = reset ? ANCHO_ESTADO'(estado_q) : '0;

  assign EscrPC     = ctrl.escr_pc;
  assign EscrPCCond = ctrl.escr_pc_cond;
  assign EscrIR     = ctrl.escr_ir;
  assign IorD       = ctrl.iord;
  assign LeerMem    = ctrl.leer_mem;
  assign EscrMem    = ctrl.escr_mem;
  assign MemaReg    = ctrl.mema_reg;
  assign RegDest    = ctrl.reg_dest;
  assign EscrReg    = ctrl.escr_reg;
  assign FuenteALUA = ctrl.fuente_alu_a;
  assign FuenteALUB = ctrl.fuente_alu_b;
  assign ALUOp      = ctrl.alu_op;
  assign FuentePC   = ctrl.fuente_pc;

endmodule

// File: tb/tb_control_multiciclo.sv
// Directed bench for control_multiciclo; strobe words are hand-packed as
// {EscrPC,EscrPCCond,EscrIR,IorD,LeerMem,EscrMem,MemaReg,RegDest,EscrReg,FuenteALUA,FuenteALUB,ALUOp,FuentePC}.
module tb_control_multiciclo;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] instru;
  logic       oZero;
  logic       mem_listo;
  logic       EscrPC, EscrPCCond, EscrIR, IorD, LeerMem, EscrMem;
  logic       MemaReg, RegDest, EscrReg, FuenteALUA, ilegal;
  logic [1:0] FuenteALUB, ALUOp, FuentePC;
  logic [3:0] estado;
  logic [15:0] outs;

  int n_vec = 0;
  int n_err = 0;

  control_multiciclo #(.ANCHO_ESTADO(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .instru     (instru),
    .oZero      (oZero),
    .mem_listo  (mem_listo),
    .EscrPC     (EscrPC),
    .EscrPCCond (EscrPCCond),
    .EscrIR     (EscrIR),
    .IorD       (IorD),
    .LeerMem    (LeerMem),
    .EscrMem    (EscrMem),
    .MemaReg    (MemaReg),
    .RegDest    (RegDest),
    .EscrReg    (EscrReg),
    .FuenteALUA (FuenteALUA),
    .FuenteALUB (FuenteALUB),
    .ALUOp      (ALUOp),
    .FuentePC   (FuentePC),
    .estado     (estado),
    .ilegal     (ilegal)
  );

  always #5 clk = ~clk;

  assign outs = {EscrPC, EscrPCCond, EscrIR, IorD, LeerMem, EscrMem, MemaReg,
                 RegDest, EscrReg, FuenteALUA, FuenteALUB, ALUOp, FuentePC};

  // Hand-packed strobe words per state.
  localparam logic [15:0] W_ZERO    = 16'h0000;
  localparam logic [15:0] W_FETCH   = 16'hA810;
  localparam logic [15:0] W_FETCHW  = 16'h0810;
  localparam logic [15:0] W_DECODE  = 16'h0030;
  localparam logic [15:0] W_MEMADR  = 16'h0060;
  localparam logic [15:0] W_MEM_RD  = 16'h1800;
  localparam logic [15:0] W_MEM_WB  = 16'h0280;
  localparam logic [15:0] W_MEM_WR  = 16'h1400;
  localparam logic [15:0] W_EXEC_R  = 16'h0048;
  localparam logic [15:0] W_WB_R    = 16'h0180;
  localparam logic [15:0] W_EXEC_I  = 16'h0060;
  localparam logic [15:0] W_WB_I    = 16'h0080;
  localparam logic [15:0] W_BEQ_T   = 16'hC045;
  localparam logic [15:0] W_BEQ_N   = 16'h4045;
  localparam logic [15:0] W_JUMP    = 16'h8002;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs at the falling edge, then compare settled outputs.
  task automatic step(input string tag, input logic [5:0] op, input logic ml,
                      input logic oz, input logic [3:0] st, input logic [15:0] w,
                      input logic il);
    @(negedge clk);
    instru    = op;
    mem_listo = ml;
    oZero     = oz;
    #1;
    check({tag, " estado"}, {12'd0, estado}, {12'd0, st});
    check({tag, " strobes"}, outs, w);
    check({tag, " ilegal"}, {15'd0, ilegal}, {15'd0, il});
  endtask

  initial begin
    reset = 1'b0; instru = 6'b111111; mem_listo = 1'b0; oZero = 1'b0;

    step("por0", 6'b111111, 1'b1, 1'b0, 4'd0, W_ZERO, 1'b0);
    step("por1", 6'b000000, 1'b0, 1'b0, 4'd0, W_ZERO, 1'b0);
    reset = 1'b1;

    step("fetch_wait0", 6'b000000, 1'b0, 1'b0, 4'd0, W_FETCHW, 1'b0);
    step("fetch_wait1", 6'b000000, 1'b0, 1'b0, 4'd0, W_FETCHW, 1'b0);

    // R-type
    step("r_fetch",  6'b000000, 1'b1, 1'b0, 4'd0, W_FETCH,  1'b0);
    step("r_decode", 6'b000000, 1'b1, 1'b0, 4'd1, W_DECODE, 1'b0);
    step("r_exec",   6'b000000, 1'b1, 1'b0, 4'd6, W_EXEC_R, 1'b0);
    step("r_wb",     6'b000000, 1'b1, 1'b0, 4'd7, W_WB_R,   1'b0);

    // lw with two wait cycles in MEM_RD
    step("lw_fetch",  6'b100011, 1'b1, 1'b0, 4'd0, W_FETCH,  1'b0);
    step("lw_decode", 6'b100011, 1'b1, 1'b0, 4'd1, W_DECODE, 1'b0);
    step("lw_memadr", 6'b100011, 1'b1, 1'b0, 4'd2, W_MEMADR, 1'b0);
    step("lw_rd_w0",  6'b100011, 1'b0, 1'b0, 4'd3, W_MEM_RD, 1'b0);
    step("lw_rd_w1",  6'b100011, 1'b0, 1'b0, 4'd3, W_MEM_RD, 1'b0);
    step("lw_rd",     6'b100011, 1'b1, 1'b0, 4'd3, W_MEM_RD, 1'b0);
    step("lw_wb",     6'b100011, 1'b1, 1'b0, 4'd4, W_MEM_WB, 1'b0);

    // sw with one wait cycle in MEM_WR
    step("sw_fetch",  6'b101011, 1'b1, 1'b0, 4'd0, W_FETCH,  1'b0);
    step("sw_decode", 6'b101011, 1'b1, 1'b0, 4'd1, W_DECODE, 1'b0);
    step("sw_memadr", 6'b101011, 1'b1, 1'b0, 4'd2, W_MEMADR, 1'b0);
    step("sw_wr_w0",  6'b101011, 1'b0, 1'b0, 4'd5, W_MEM_WR, 1'b0);
    step("sw_wr",     6'b101011, 1'b1, 1'b0, 4'd5, W_MEM_WR, 1'b0);

    // beq taken, then not taken
    step("beqt_fetch",  6'b000100, 1'b1, 1'b0, 4'd0, W_FETCH,  1'b0);
    step("beqt_decode", 6'b000100, 1'b1, 1'b0, 4'd1, W_DECODE, 1'b0);
    step("beqt_branch", 6'b000100, 1'b1, 1'b1, 4'd8, W_BEQ_T,  1'b0);
    step("beqn_fetch",  6'b000100, 1'b1, 1'b0, 4'd0, W_FETCH,  1'b0);
    step("beqn_decode", 6'b000100, 1'b1, 1'b0, 4'd1, W_DECODE, 1'b0);
    step("beqn_branch", 6'b000100, 1'b1, 1'b0, 4'd8, W_BEQ_N,  1'b0);

    // addi
    step("addi_fetch",  6'b001000, 1'b1, 1'b0, 4'd0,  W_FETCH,  1'b0);
    step("addi_decode", 6'b001000, 1'b1, 1'b0, 4'd1,  W_DECODE, 1'b0);
    step("addi_exec",   6'b001000, 1'b1, 1'b0, 4'd9,  W_EXEC_I, 1'b0);
    step("addi_wb",     6'b001000, 1'b1, 1'b0, 4'd10, W_WB_I,   1'b0);

    // illegal opcode
    step("ill_fetch",  6'b111111, 1'b1, 1'b0, 4'd0, W_FETCH,  1'b0);
    step("ill_decode", 6'b111111, 1'b1, 1'b0, 4'd1, W_DECODE, 1'b1);

    // j
    step("j_fetch",  6'b000010, 1'b1, 1'b0, 4'd0, W_FETCH,  1'b0);
`ifdef JUMP_EN
    step("j_decode", 6'b000010, 1'b1, 1'b0, 4'd1,  W_DECODE, 1'b0);
    step("j_jump",   6'b000010, 1'b1, 1'b0, 4'd11, W_JUMP,   1'b0);
`else
    step("j_decode", 6'b000010, 1'b1, 1'b0, 4'd1, W_DECODE, 1'b1);
`endif

    // reset asserted while lw waits in MEM_RD
    step("lwr_fetch",  6'b100011, 1'b1, 1'b0, 4'd0, W_FETCH,  1'b0);
    step("lwr_decode", 6'b100011, 1'b1, 1'b0, 4'd1, W_DECODE, 1'b0);
    step("lwr_memadr", 6'b100011, 1'b1, 1'b0, 4'd2, W_MEMADR, 1'b0);
    step("lwr_rd_w",   6'b100011, 1'b0, 1'b0, 4'd3, W_MEM_RD, 1'b0);
    reset = 1'b0;
    step("lwr_rst0", 6'b100011, 1'b1, 1'b0, 4'd0, W_ZERO, 1'b0);
    step("lwr_rst1", 6'b100011, 1'b1, 1'b0, 4'd0, W_ZERO, 1'b0);
    step("lwr_rst2", 6'b100011, 1'b0, 1'b0, 4'd0, W_ZERO, 1'b0);
    reset = 1'b1;
    step("post_fetch",  6'b000000, 1'b1, 1'b0, 4'd0, W_FETCH,  1'b0);
    step("post_decode", 6'b000000, 1'b1, 1'b0, 4'd1, W_DECODE, 1'b0);
    step("post_exec",   6'b000000, 1'b1, 1'b0, 4'd6, W_EXEC_R, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
